// File: rtl/seg_frame_decoder_if.sv
// Display-bus interface: sampled seven-segment byte in, decoded frame out.
interface seg_frame_decoder_if;
    logic [7:0] ui_in;
    logic [6:0] value;
    logic [3:0] uni;
    logic [3:0] dec;
    logic       valid;
    logic       err;
    logic       seq_err;

    modport master (
        output ui_in,
        input  value, uni, dec, valid, err, seq_err
    );

    modport slave (
        input  ui_in,
        output value, uni, dec, valid, err, seq_err
    );
endinterface

// File: rtl/seg_frame_decoder.sv
// Loopback checker: filters the muxed two-digit segment bus and rebuilds 0-99 frames.
module seg_frame_decoder #(
    parameter int unsigned STABLE_CYCLES = 2
) (
    input logic               clk,
    input logic               rst,
    seg_frame_decoder_if.slave bus
);
    typedef enum logic {WAIT_UNI, WAIT_DEC} state_t;

    localparam logic [3:0] SC = 4'(STABLE_CYCLES);

    logic [7:0] r_s;
    logic [3:0] r_run;
    logic       r_done;
    state_t     r_state;
    state_t     w_next;
    logic [3:0] r_pend;
    logic [6:0] r_value;
    logic [3:0] r_uni;
    logic [3:0] r_dec;
    logic       r_valid;
    logic       r_err;
    logic       r_seq;
    logic       r_have;

    logic       w_change;
    logic       w_accept;
    logic       w_legal;
    logic [3:0] w_digit;
    logic       w_load;
    logic       w_commit;
    logic       w_illegal;
    logic [6:0] w_new;
    logic [6:0] w_succ;
    logic       w_seq_bad;

    assign w_change = bus.ui_in != r_s;
    assign w_accept = (r_run == SC) && !r_done;

    // r_done marks the current stable run as consumed; a new byte re-arms it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_run  <= '0;
            r_done <= 1'b0;
        end else begin
            r_s <= bus.ui_in;
            if (w_change) begin
                r_run  <= 4'd1;
                r_done <= 1'b0;
            end else begin
                r_run  <= (r_run >= SC) ? SC : r_run + 4'd1;
                r_done <= r_done | w_accept;
            end
        end
    end

    always_comb begin
        w_legal = 1'b1;
        w_digit = 4'd0;
        case (r_s[6:0])
            7'b1000000: w_digit = 4'd0;
            7'b1111001: w_digit = 4'd1;
            7'b0100100: w_digit = 4'd2;
            7'b0110000: w_digit = 4'd3;
            7'b0011001: w_digit = 4'd4;
            7'b0010010: w_digit = 4'd5;
            7'b0000010: w_digit = 4'd6;
            7'b1111000: w_digit = 4'd7;
            7'b0000000: w_digit = 4'd8;
            7'b0010000: w_digit = 4'd9;
            default:    w_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_next    = r_state;
        w_load    = 1'b0;
        w_commit  = 1'b0;
        w_illegal = 1'b0;
        if (w_accept) begin
            if (!w_legal) begin
                w_illegal = 1'b1;
                w_next    = WAIT_UNI;
            end else if (!r_s[7]) begin
                w_load = 1'b1;
                w_next = WAIT_DEC;
            end else if (r_state == WAIT_DEC) begin
                w_commit = 1'b1;
                w_next   = WAIT_UNI;
            end
        end
    end

    assign w_new     = {3'b000, w_digit} * 7'd10 + {3'b000, r_pend};
    assign w_succ    = (r_value == 7'd99) ? 7'd0 : r_value + 7'd1;
    assign w_seq_bad = r_have && (w_new != r_value) && (w_new != w_succ);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT_UNI;
            r_pend  <= '0;
            r_value <= '0;
            r_uni   <= '0;
            r_dec   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_seq   <= 1'b0;
            r_have  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_commit;
            r_err   <= w_illegal;
            r_seq   <= w_commit & w_seq_bad;
            if (w_load) begin
                r_pend <= w_digit;
            end
            if (w_commit) begin
                r_uni   <= r_pend;
                r_dec   <= w_digit;
                r_value <= w_new;
                r_have  <= 1'b1;
            end
        end
    end

    assign bus.value   = r_value;
    assign bus.uni     = r_uni;
    assign bus.dec     = r_dec;
    assign bus.valid   = r_valid;
    assign bus.err     = r_err;
    assign bus.seq_err = r_seq;
endmodule

// File: tb/tb_seg_frame_decoder.sv
// Bench for seg_frame_decoder: directed plan scenarios plus randomized slots vs a frame model.
module tb_seg_frame_decoder;
    localparam int SC = 2;

    logic clk;
    logic rst;

    seg_frame_decoder_if bus ();

    seg_frame_decoder #(.STABLE_CYCLES(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] pat [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int n_chk = 0;
    int n_err = 0;

    // model state: the byte being watched, how often seen in a row, frame bookkeeping
    logic [7:0] m_byte;
    int         m_seen;
    bit         m_used;
    int         m_pend;
    bit         m_have;
    int         m_prev;
    bit         m_live = 0;
    int         e_value, e_uni, e_dec;
    bit         e_valid, e_err, e_seq;

    int n_valid = 0;
    int n_errp  = 0;
    int n_seqp  = 0;
    int last_val = -1;
    int last_seq = -1;

    function automatic int dig(input logic [6:0] p);
        for (int k = 0; k < 10; k++)
            if (pat[k] == p) return k;
        return -1;
    endfunction

    task automatic take(input logic [7:0] b);
        int d;
        int nv;
        d = dig(b[6:0]);
        if (d < 0) begin
            e_err  = 1;
            m_pend = -1;
        end else if (!b[7]) begin
            m_pend = d;
        end else if (m_pend >= 0) begin
            nv = d * 10 + m_pend;
            e_valid = 1;
            e_seq   = m_have && nv != m_prev && nv != (m_prev + 1) % 100;
            e_uni   = m_pend;
            e_dec   = d;
            e_value = nv;
            m_prev  = nv;
            m_have  = 1;
            m_pend  = -1;
        end
    endtask

    // applies the rising edge that just happened, using the inputs it saw
    task automatic model_edge();
        if (rst) begin
            m_byte = 8'h00; m_seen = 0; m_used = 0; m_pend = -1;
            m_have = 0; m_prev = 0; m_live = 1;
            e_value = 0; e_uni = 0; e_dec = 0;
            e_valid = 0; e_err = 0; e_seq = 0;
        end else begin
            e_valid = 0; e_err = 0; e_seq = 0;
            if (m_seen == SC && !m_used) begin
                m_used = 1;
                take(m_byte);
            end
            if (bus.ui_in != m_byte) begin
                m_byte = bus.ui_in; m_seen = 1; m_used = 0;
            end else if (m_seen < SC) begin
                m_seen++;
            end
        end
    endtask

    task automatic compare();
        if (!m_live) return;
        n_chk++;
        if (bus.value !== 7'(e_value) || bus.uni !== 4'(e_uni) ||
            bus.dec !== 4'(e_dec) || bus.valid !== e_valid ||
            bus.err !== e_err || bus.seq_err !== e_seq) begin
            n_err++;
            $display("FAIL cycle t=%0t dut v=%0d u=%0d d=%0d val=%b e=%b s=%b model v=%0d u=%0d d=%0d val=%b e=%b s=%b",
                     $time, bus.value, bus.uni, bus.dec, bus.valid, bus.err, bus.seq_err,
                     e_value, e_uni, e_dec, e_valid, e_err, e_seq);
        end
        if (bus.valid === 1'b1) begin
            n_valid++;
            last_val = int'(bus.value);
            last_seq = int'(bus.seq_err);
        end
        if (bus.err === 1'b1) n_errp++;
        if (bus.seq_err === 1'b1) n_seqp++;
    endtask

    task automatic cyc(input logic [7:0] b, input logic r);
        @(negedge clk);
        model_edge();
        compare();
        bus.ui_in = b;
        rst = r;
    endtask

    task automatic slot(input logic [7:0] b, input int n);
        repeat (n) cyc(b, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(bus.ui_in, 1'b0);
    endtask

    task automatic frame(input int u, input int d);
        slot({1'b0, pat[u]}, 2);
        slot({1'b1, pat[d]}, 2);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    initial begin
        int v0, e0, s0, cnt;
        logic [7:0] b;
        rst = 1'b1;
        bus.ui_in = 8'h00;

        b = 8'($urandom);
        repeat (3) begin
            b = b ^ 8'(1 + $urandom_range(0, 254));
            cyc(b, 1'b1);
        end
        repeat (2) begin
            b = b ^ 8'(1 + $urandom_range(0, 254));
            cyc(b, 1'b0);
        end
        idle(1);
        chk("rst_value", int'(bus.value), 0);
        chk("rst_pulses", n_valid + n_errp + n_seqp, 0);

        v0 = n_valid;
        frame(7, 4);
        idle(2);
        chk("f47_valid", n_valid - v0, 1);
        chk("f47_value", last_val, 47);
        chk("f47_uni", int'(bus.uni), 7);
        chk("f47_dec", int'(bus.dec), 4);
        chk("f47_seq", last_seq, 0);

        v0 = n_valid; e0 = n_errp;
        slot({1'b0, pat[8]}, 2);
        slot({1'b0, pat[2]}, 1);
        slot({1'b1, pat[4]}, 2);
        idle(2);
        chk("glitch_err", n_errp - e0, 0);
        chk("glitch_value", last_val, 48);

        v0 = n_valid; e0 = n_errp;
        slot(8'h7F, 2);
        slot({1'b1, pat[4]}, 2);
        idle(1);
        chk("ill_err", n_errp - e0, 1);
        chk("ill_novalid", n_valid - v0, 0);
        frame(9, 4);
        idle(2);
        chk("ill_recover", last_val, 49);

        frame(7, 9);
        idle(2);
        v0 = n_valid; s0 = n_seqp;
        frame(8, 9);
        frame(9, 9);
        frame(0, 0);
        frame(0, 0);
        idle(2);
        chk("seq_valids", n_valid - v0, 4);
        chk("seq_noerr", n_seqp - s0, 0);
        frame(5, 0);
        idle(2);
        chk("seq_jump", n_seqp - s0, 1);
        chk("seq_value", last_val, 5);
        chk("seq_flag", last_seq, 1);

        v0 = n_valid;
        slot({1'b0, pat[3]}, 3);
        cyc({1'b1, pat[2]}, 1'b1);
        slot({1'b1, pat[2]}, 3);
        chk("mid_novalid", n_valid - v0, 0);
        chk("mid_value", int'(bus.value), 0);
        frame(1, 2);
        idle(2);
        chk("mid_value2", last_val, 21);
        chk("mid_seq", last_seq, 0);

        cnt = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) < 7) begin
                if ($urandom_range(0, 4) != 0) cnt = (cnt + 1) % 100;
                slot({1'b0, pat[cnt % 10]}, $urandom_range(1, 3));
                slot({1'b1, pat[cnt / 10]}, $urandom_range(1, 3));
            end else if ($urandom_range(0, 3) == 0) begin
                slot(8'($urandom), $urandom_range(1, 3));
            end else begin
                slot({1'($urandom), pat[$urandom_range(0, 9)]}, $urandom_range(1, 3));
            end
            if ($urandom_range(0, 199) == 0) cyc(bus.ui_in, 1'b1);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/seg_frame_decoder.md
# seg_frame_decoder

Receive-side decoder for the two-digit multiplexed seven-segment bus that the counter produces: `{an, seg[6:0]}`, active-low segments, `an=0` units / `an=1` tens. It samples the bus and applies a stability filter to each digit slot. It converts the segment patterns back to BCD and assembles units+tens frames into a binary value 0–99. It flags illegal patterns and counting-sequence violations, and is used as an on-chip loopback checker for the display path.

## Interface
- `STABLE_CYCLES`, default 2: consecutive identical samples required before a bus byte is accepted; legal range 1–15.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `ui_in`  in  8  display bus: bit 7 = `an`, bits 6:0 = `seg` (gfedcba, active-low).
- `value`  out  7  last complete frame as binary, `dec*10+uni`.
- `uni`  out  4  last accepted units digit of the last complete frame.
- `dec`  out  4  last accepted tens digit of the last complete frame.
- `valid`  out  1  one-cycle pulse: new frame loaded into `value/uni/dec`.
- `err`  out  1  one-cycle pulse: accepted byte had an illegal segment pattern.
- `seq_err`  out  1  one-cycle pulse: new frame is neither previous value nor previous+1 mod 100.

## Operation
- Sample register `s` <= `ui_in` every cycle. Run counter `run` is saturating at `STABLE_CYCLES` and 4 bits wide:
  - `run` <= 1 when `ui_in != s`;
  - otherwise `run` <= min(`run`+1, `STABLE_CYCLES`).
- Accept event: `run == STABLE_CYCLES` and the current run has not yet been accepted. Exactly one accept per stable run; a flag clears when `run` restarts.
- Decode of `s[6:0]`:
  - 1000000=0, 1111001=1, 0100100=2, 0110000=3, 0011001=4, 0010010=5, 0000010=6, 1111000=7, 0000000=8, 0010000=9.
  - Anything else, blank 1111111 included, is illegal.
- FSM with two states, WAIT_UNI (reset) and WAIT_DEC:
  - WAIT_UNI, legal accept with `an=0`: store pending units, go WAIT_DEC.
  - WAIT_UNI, legal accept with `an=1`: ignore and stay. This resynchronises to units-first.
  - WAIT_DEC, legal accept with `an=1`: commit frame. `uni`, `dec` and `value` are updated, `valid` pulses, go WAIT_UNI.
  - WAIT_DEC, legal accept with `an=0`: overwrite pending units, stay.
  - Any state, illegal accept: pulse `err`, discard pending units, go WAIT_UNI. Outputs hold.
- Value arithmetic: `value = dec*10 + uni`, computed at 7 bits. Max 99, no overflow.
- Sequence check runs at each commit when flag `have_prev` is set:
  - `seq_err` pulses with `valid` if new ≠ old and new ≠ (old==99 ? 0 : old+1).
  - `have_prev` sets on first commit after reset. The first frame never raises `seq_err`.
- Reset mid-operation: the next edge with `rst=1` clears all state regardless of FSM position. Pending digits are discarded.

## Timing
- Reset values:
  - `value=0`, `uni=0`, `dec=0`, `valid=0`, `err=0`, `seq_err=0`;
  - `s=0`, `run=0`, FSM=WAIT_UNI, `have_prev=0`.
- Latency. Define edge t as the first edge sampling a new byte. With that byte held through edge t+STABLE_CYCLES−1:
  - the accept is registered at edge t+STABLE_CYCLES;
  - a tens accept drives `valid`/`seq_err`, and an illegal accept drives `err`, high for the one cycle following that edge.
- With `STABLE_CYCLES=2`, a digit slot of 2 cycles (the counter mux rate) is sufficient. A 1-cycle slot is filtered out.
- `valid`, `err` and `seq_err` are registered and glitch-free. They are never high for two consecutive cycles from the same run.
- `valid` and `err` are mutually exclusive in a cycle.

## Test plan
- Reset: assert `rst` for 3 cycles with random `ui_in` -> all outputs 0; no pulses for 2 cycles after release with `ui_in` changing every cycle.
- Frame decode: `ui_in`=0_1111000 for 2 cycles, then 1_0011001 for 2 cycles -> `valid` one cycle, `uni=7`, `dec=4`, `value=47`, `seq_err=0`.
- Glitch filter: 0_0100100 for 1 cycle between two stable slots -> ignored, no `err`, frame value unchanged by the glitch.
- Illegal pattern: units 0_1111111 for 2 cycles -> `err` pulse, no `valid`. The following tens slot is ignored, and the next legal units+tens pair commits normally.
- Sequence: frames 98, 99, 00, 00 -> four `valid`, no `seq_err`. Next frame 05 -> `seq_err` with `valid`, `value=5`.
- Reset mid-frame: units 3 accepted, `rst` for 1 cycle, then tens 2 -> no `valid`, `value=0`. A following units 1 + tens 2 gives `value=21` and `seq_err=0` (first frame).
